fft_window_buffer: RTL and testbench
====================================

FFT_WINDOW_BUFFER -- requirements
Module: fft_window_buffer

Interface
REQ-001 Parameter DATA_W, 32, bit width of each I and Q sample.
REQ-002 Parameter N, 32, window depth in samples; power of two, 4..256.
REQ-003 Parameter HOP, 32, number of accepted samples between frames after the initial fill; 1 <= HOP <= N.
REQ-004 clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  synchronous restart of window filling.
REQ-007 in_valid  input  1  I/Q sample present.
REQ-008 I  input  DATA_W  real sample.
REQ-009 Q  input  DATA_W  imaginary sample.
REQ-010 in_ready  output  1  sample accepted when in_valid && in_ready.
REQ-011 win_real  output  N*DATA_W  flattened real taps; tap k occupies bits [k*DATA_W +: DATA_W]; tap 0 is the newest sample.
REQ-012 win_imag  output  N*DATA_W  flattened imaginary taps, same layout.
REQ-013 frame_valid  output  1  window is complete and stable.
REQ-014 frame_ready  input  1  downstream FFT takes the frame when frame_valid && frame_ready.
REQ-015 busy  output  1  high in any state except IDLE.

Function
REQ-016 Accepting a sample SHALL shift tap k into tap k+1 for all k, and load I/Q into tap 0, at the same edge.
- Tap N-1 is discarded.
REQ-017 The FSM SHALL have the states IDLE, FILL, RUN and HOLD.
- IDLE -> FILL on the first accepted sample.
- FILL -> HOLD when the Nth accepted sample is taken.
- RUN -> HOLD when the HOPth accepted sample since the last frame is taken.
- HOLD -> RUN on frame acceptance.
REQ-018 frame_valid SHALL be high exactly in HOLD, starting in the cycle after the edge that accepted the completing sample.
- Latency is 1 cycle.
REQ-019 Tap contents SHALL NOT change while frame_valid is high and frame_ready is low.
REQ-020 in_ready SHALL equal !frame_valid || frame_ready.
- A sample and a frame acceptance in the same cycle SHALL both take effect.
- That sample counts as the first of the next HOP.
- If HOP==1, frame_valid SHALL reassert in the following cycle.
REQ-021 The fill counter SHALL be log2(N)+1 bits and the hop counter log2(HOP)+1 bits.
- Both SHALL clear when their state is exited; neither SHALL wrap while in use.
REQ-022 When flush is high, the FSM SHALL go to IDLE, both counters SHALL clear, and frame_valid SHALL drop the next cycle.
- Taps are retained.
- flush has priority over in_valid and frame_ready in that cycle; a sample presented then is not accepted.
REQ-023 When HOP == N, frames SHALL be non-overlapping; when HOP < N, consecutive frames SHALL share N-HOP samples.

Reset
REQ-024 While reset is high, all taps, counters and outputs SHALL be zero and the FSM SHALL be in IDLE, so frame_valid=0, busy=0 and in_ready=1.
REQ-025 Reset asserted in the middle of a frame SHALL discard that frame with no further frame_valid.
REQ-026 Reset SHALL take priority over flush.

Configuration
REQ-027 With WINBUF_DROP_CNT_EN defined, the block SHALL have an output drop_cnt, 16 bits wide.
- It increments on each cycle with in_valid && !in_ready && !flush.
- It saturates at 0xFFFF.
- It is cleared by reset only.
REQ-028 Without WINBUF_DROP_CNT_EN, the drop_cnt port and its logic SHALL be absent.
- All other behaviour is unchanged.

Structure
REQ-029 Shared package fft_pkg SHALL hold the FSM state typedef (IDLE, FILL, RUN, HOLD), the default DATA_W and N, and the limits N_MIN=4 and N_MAX=256.
REQ-030 The FSM, counters and in_ready logic SHALL be in the sub-module winbuf_ctrl.
- The top level holds the tap register array and the optional drop counter.
- Illegal parameters SHALL cause an elaboration error.

Verification
REQ-031 Fill: with N=32 and HOP=32, feed samples 1..32 continuously with frame_ready=1.
- frame_valid pulses 1 cycle, in the cycle after sample 32 is accepted.
- tap0 = 32 and tap31 = 1.
REQ-032 Overlap: with N=8 and HOP=2, feed 20 samples with frame_ready=1.
- Frames occur after samples 8, 10, 12, ..., 20 (7 frames).
- Each frame's tap0 is the newest sample.
REQ-033 Backpressure: hold frame_ready=0 for 5 cycles with in_valid=1.
- Taps are stable and in_ready=0.
- With WINBUF_DROP_CNT_EN, drop_cnt=5.
- Samples resume on the frame_ready=1 cycle.
REQ-034 Flush mid-fill: after 5 samples, pulse flush with in_valid=1.
- That sample is rejected and the FSM returns to IDLE.
- 32 new samples are required before the next frame_valid.
REQ-035 Reset mid-HOLD: assert reset while frame_valid=1.
- The next cycle shows frame_valid=0, busy=0, all taps 0 and drop_cnt 0.
REQ-036 HOP=1: keep frame_ready=1 and in_valid=1 continuously after fill.
- frame_valid stays high every cycle.
- Each frame's window shifts by exactly one sample.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FSM state type, default sizes and legal window limits for the FFT window buffer.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    HOLD
  } winbuf_state_e;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned N_DEF      = 32;
  localparam int unsigned HOP_DEF    = 32;
  localparam int unsigned N_MIN      = 4;
  localparam int unsigned N_MAX      = 256;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fft_window_buffer_if.sv
// Sample-in / frame-out handshake bundle of the FFT window buffer.
interface fft_window_buffer_if #(
  parameter int unsigned DATA_W = fft_pkg::DATA_W_DEF,
  parameter int unsigned N      = fft_pkg::N_DEF
);

  logic                in_valid;
  logic [DATA_W-1:0]   I;
  logic [DATA_W-1:0]   Q;
  logic                in_ready;
  logic [N*DATA_W-1:0] win_real;
  logic [N*DATA_W-1:0] win_imag;
  logic                frame_valid;
  logic                frame_ready;

  modport master (
    output in_valid, I, Q, frame_ready,
    input  in_ready, win_real, win_imag, frame_valid
  );

  modport slave (
    input  in_valid, I, Q, frame_ready,
    output in_ready, win_real, win_imag, frame_valid
  );

endinterface

// File: rtl/winbuf_ctrl.sv
// Window buffer control: IDLE/FILL/RUN/HOLD sequencing, fill and hop counters, sample handshake.
module winbuf_ctrl import fft_pkg::*; #(
  parameter int unsigned N   = N_DEF,
  parameter int unsigned HOP = HOP_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic in_valid,
  input  logic frame_ready,
  output logic in_ready,
  output logic accept,
  output logic frame_valid,
  output logic busy
);

  localparam int unsigned FILL_W = $clog2(N) + 1;
  localparam int unsigned HOP_W  = $clog2(HOP) + 1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(N - 1);
  localparam logic [HOP_W-1:0]  HOP_LAST  = HOP_W'(HOP - 1);

  winbuf_state_e     state_q, state_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [HOP_W-1:0]  hop_cnt_q, hop_cnt_d;
  logic              frame_take;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fill_cnt_q <= '0;
      hop_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      hop_cnt_q  <= hop_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    hop_cnt_d  = hop_cnt_q;
    if (flush) begin
      state_d    = IDLE;
      fill_cnt_d = '0;
      hop_cnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d    = FILL;
            fill_cnt_d = FILL_W'(1);
          end
        end
        FILL: begin
          if (accept) begin
            if (fill_cnt_q == FILL_LAST) begin
              state_d    = HOLD;
              fill_cnt_d = '0;
            end else begin
              fill_cnt_d = fill_cnt_q + 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            if (hop_cnt_q == HOP_LAST) begin
              state_d   = HOLD;
              hop_cnt_d = '0;
            end else begin
              hop_cnt_d = hop_cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          // A sample taken alongside the frame is the first of the next hop,
          // so with HOP==1 it already completes the next frame.
          if (frame_take) begin
            if (accept && HOP == 1) begin
              state_d = HOLD;
            end else if (accept) begin
              state_d   = RUN;
              hop_cnt_d = HOP_W'(1);
            end else begin
              state_d = RUN;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Reset masks the outputs immediately so a held frame vanishes in the reset cycle.
  always_comb begin
    frame_valid = (state_q == HOLD) && !reset;
    busy        = (state_q != IDLE) && !reset;
    in_ready    = !frame_valid || frame_ready;
    frame_take  = frame_valid && frame_ready && !flush;
    accept      = in_valid && in_ready && !flush && !reset;
  end

endmodule

// File: rtl/fft_window_buffer.sv
// Sliding I/Q tap window feeding an FFT; optional drop counter under WINBUF_DROP_CNT_EN.
module fft_window_buffer import fft_pkg::*; #(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned N      = N_DEF,
  parameter int unsigned HOP    = HOP_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  fft_window_buffer_if.slave  bus,
  output logic                busy
`ifdef WINBUF_DROP_CNT_EN
  ,
  output logic [15:0]         drop_cnt
`endif
);

  if (!is_pow2(N) || N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("fft_window_buffer: N=%0d must be a power of two in [%0d,%0d]", N, N_MIN, N_MAX);
  end
  if (HOP < 1 || HOP > N) begin : g_bad_hop
    $error("fft_window_buffer: HOP=%0d must lie in [1,N=%0d]", HOP, N);
  end
  if (DATA_W < 1) begin : g_bad_dw
    $error("fft_window_buffer: DATA_W must be at least 1");
  end

  logic                accept;
  logic [N*DATA_W-1:0] real_q, real_d;
  logic [N*DATA_W-1:0] imag_q, imag_d;

  winbuf_ctrl #(
    .N   (N),
    .HOP (HOP)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (bus.in_valid),
    .frame_ready (bus.frame_ready),
    .in_ready    (bus.in_ready),
    .accept      (accept),
    .frame_valid (bus.frame_valid),
    .busy        (busy)
  );

  always_comb begin
    real_d = real_q;
    imag_d = imag_q;
    if (accept) begin
      real_d = {real_q[(N-1)*DATA_W-1:0], bus.I};
      imag_d = {imag_q[(N-1)*DATA_W-1:0], bus.Q};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      real_q <= '0;
      imag_q <= '0;
    end else begin
      real_q <= real_d;
      imag_q <= imag_d;
    end
  end

  always_comb begin
    bus.win_real = real_q;
    bus.win_imag = imag_q;
  end

`ifdef WINBUF_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.in_valid && !bus.in_ready && !flush && drop_cnt_q != '1) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fft_window_buffer.sv
// Scoreboard bench for fft_window_buffer: three configurations (N/HOP = 32/32, 8/2, 4/1).
module tb_fft_window_buffer;

  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic busy_a, busy_b, busy_c;
`ifdef WINBUF_DROP_CNT_EN
  logic [15:0] drop_a, drop_b, drop_c;
`endif

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int qa[$];
  int qb[$];
  int qc[$];
  int frames_b = 0;
  int frames_c = 0;

  always #5 clk = ~clk;

  fft_window_buffer_if #(.DATA_W(DW), .N(32)) bus_a ();
  fft_window_buffer_if #(.DATA_W(DW), .N(8))  bus_b ();
  fft_window_buffer_if #(.DATA_W(DW), .N(4))  bus_c ();

  fft_window_buffer #(.DATA_W(DW), .N(32), .HOP(32)) u_a (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus_a), .busy(busy_a)
`ifdef WINBUF_DROP_CNT_EN
    , .drop_cnt(drop_a)
`endif
  );

  fft_window_buffer #(.DATA_W(DW), .N(8), .HOP(2)) u_b (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus_b), .busy(busy_b)
`ifdef WINBUF_DROP_CNT_EN
    , .drop_cnt(drop_b)
`endif
  );

  fft_window_buffer #(.DATA_W(DW), .N(4), .HOP(1)) u_c (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus_c), .busy(busy_c)
`ifdef WINBUF_DROP_CNT_EN
    , .drop_cnt(drop_c)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Expected window after sample `newest`: tap k holds newest-k, imag = real + 1000.
  task automatic chk_win(input string name, input logic [1023:0] wr, input logic [1023:0] wi,
                         input int n, input int newest);
    int errs;
    errs = 0;
    for (int k = 0; k < n; k++) begin
      if (wr[k*32 +: 32] !== 32'(newest - k)) errs++;
      if (wi[k*32 +: 32] !== 32'(newest - k + 1000)) errs++;
    end
    chk({name, "_tap0"}, 64'(wr[31:0]), 64'(newest));
    chk({name, "_tap_last"}, 64'(wr[(n-1)*32 +: 32]), 64'(newest - n + 1));
    chk({name, "_bad_taps"}, 64'(errs), 64'd0);
  endtask

  always @(negedge clk) begin
    if (bus_a.frame_valid && bus_a.frame_ready) begin
      if (qa.size() == 0) begin
        n_total++;
        $display("FAIL frame_a: unexpected frame tap0=%0d, none expected", bus_a.win_real[31:0]);
      end else begin
        int e;
        e = qa.pop_front();
        chk_win("frame_a", 1024'(bus_a.win_real), 1024'(bus_a.win_imag), 32, e);
      end
    end
  end

  always @(negedge clk) begin
    if (bus_b.frame_valid && bus_b.frame_ready) begin
      frames_b++;
      if (qb.size() == 0) begin
        n_total++;
        $display("FAIL frame_b: unexpected frame tap0=%0d, none expected", bus_b.win_real[31:0]);
      end else begin
        int e;
        e = qb.pop_front();
        chk_win("frame_b", 1024'(bus_b.win_real), 1024'(bus_b.win_imag), 8, e);
      end
    end
  end

  always @(negedge clk) begin
    if (bus_c.frame_valid && bus_c.frame_ready) begin
      frames_c++;
      if (qc.size() == 0) begin
        n_total++;
        $display("FAIL frame_c: unexpected frame tap0=%0d, none expected", bus_c.win_real[31:0]);
      end else begin
        int e;
        e = qc.pop_front();
        chk_win("frame_c", 1024'(bus_c.win_real), 1024'(bus_c.win_imag), 4, e);
      end
    end
  end

  task automatic send_a(input int v);
    bus_a.in_valid = 1'b1; bus_a.I = DW'(v); bus_a.Q = DW'(v + 1000);
    @(posedge clk); #1;
  endtask

  task automatic send_b(input int v);
    bus_b.in_valid = 1'b1; bus_b.I = DW'(v); bus_b.Q = DW'(v + 1000);
    @(posedge clk); #1;
  endtask

  task automatic send_c(input int v);
    bus_c.in_valid = 1'b1; bus_c.I = DW'(v); bus_c.Q = DW'(v + 1000);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.I = '0; bus_a.Q = '0; bus_a.frame_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.I = '0; bus_b.Q = '0; bus_b.frame_ready = 1'b1;
    bus_c.in_valid = 1'b0; bus_c.I = '0; bus_c.Q = '0; bus_c.frame_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fv_a", 64'(bus_a.frame_valid), 64'd0);
    chk("rst_busy_a", 64'(busy_a), 64'd0);
    chk("rst_in_ready_a", 64'(bus_a.in_ready), 64'd1);
    chk("rst_taps_a", 64'(|{bus_a.win_real, bus_a.win_imag}), 64'd0);
    chk("rst_busy_bc", 64'({busy_b, busy_c}), 64'd0);
    reset = 1'b0;

    // Fill: samples 1..32, single-cycle frame pulse.
    for (int v = 1; v <= 32; v++) begin
      if (v == 32) qa.push_back(32);
      send_a(v);
      if (v == 31) chk("fill_fv_before_last", 64'(bus_a.frame_valid), 64'd0);
    end
    chk("fill_fv_on", 64'(bus_a.frame_valid), 64'd1);
    chk("fill_busy", 64'(busy_a), 64'd1);
    bus_a.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("fill_fv_pulse_end", 64'(bus_a.frame_valid), 64'd0);

    // Backpressure: frame held for 5 cycles while a sample waits.
    bus_a.frame_ready = 1'b0;
    for (int v = 33; v <= 64; v++) send_a(v);
    chk("bp_fv_on", 64'(bus_a.frame_valid), 64'd1);
    qa.push_back(64);
    bus_a.I = DW'(65); bus_a.Q = DW'(1065);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 64'(bus_a.in_ready), 64'd0);
      chk("bp_tap0_stable", 64'(bus_a.win_real[31:0]), 64'd64);
    end
`ifdef WINBUF_DROP_CNT_EN
    chk("bp_drop_cnt", 64'(drop_a), 64'd5);
`endif
    bus_a.frame_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_resume_tap0", 64'(bus_a.win_real[31:0]), 64'd65);
    chk("bp_resume_fv", 64'(bus_a.frame_valid), 64'd0);
    bus_a.in_valid = 1'b0;

    // Flush mid-fill: sample presented with flush is rejected.
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle_busy", 64'(busy_a), 64'd0);
    for (int v = 101; v <= 105; v++) send_a(v);
    chk("flush_fill_busy", 64'(busy_a), 64'd1);
    flush = 1'b1;
    bus_a.I = DW'(106); bus_a.Q = DW'(1106);
    @(posedge clk); #1;
    flush = 1'b0;
    bus_a.in_valid = 1'b0;
    chk("flush_reject_tap0", 64'(bus_a.win_real[31:0]), 64'd105);
    chk("flush_busy", 64'(busy_a), 64'd0);
    for (int v = 201; v <= 232; v++) begin
      if (v == 232) qa.push_back(232);
      send_a(v);
      if (v == 231) chk("refill_fv_before_32", 64'(bus_a.frame_valid), 64'd0);
    end
    chk("refill_fv_on", 64'(bus_a.frame_valid), 64'd1);
    bus_a.in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset while a frame is held.
    bus_a.frame_ready = 1'b0;
    for (int v = 301; v <= 332; v++) send_a(v);
    bus_a.in_valid = 1'b0;
    chk("hold_fv_on", 64'(bus_a.frame_valid), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_fv", 64'(bus_a.frame_valid), 64'd0);
    chk("rstmid_busy", 64'(busy_a), 64'd0);
    chk("rstmid_taps", 64'(|{bus_a.win_real, bus_a.win_imag}), 64'd0);
`ifdef WINBUF_DROP_CNT_EN
    chk("rstmid_drop_cnt", 64'(drop_a), 64'd0);
`endif
    reset = 1'b0;
    bus_a.frame_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rstmid_fv_stays_low", 64'(bus_a.frame_valid), 64'd0);

    // Overlap N=8 HOP=2: frames after 8,10,...,20.
    for (int v = 1; v <= 20; v++) begin
      if (v >= 8 && (v % 2) == 0) qb.push_back(v);
      send_b(v);
    end
    bus_b.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("overlap_frame_count", 64'(frames_b), 64'd7);

    // HOP=1 N=4: frame_valid held every cycle once filled.
    for (int v = 1; v <= 10; v++) begin
      if (v >= 4) qc.push_back(v);
      send_c(v);
      if (v >= 4) chk("hop1_fv_high", 64'(bus_c.frame_valid), 64'd1);
    end
    bus_c.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("hop1_fv_drop", 64'(bus_c.frame_valid), 64'd0);
    chk("hop1_frame_count", 64'(frames_c), 64'd7);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(qa.size() + qb.size() + qc.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
